// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
//   - Default data and register-index widths.
//   - Producer stage indices (EX is the youngest producer).
//   - FSM state encoding.
package fwd_hazard_unit_pkg;

  localparam int unsigned XlenDef = 32;
  localparam int unsigned RegwDef = 5;

  // Producer stage indices; a lower index means a younger producer.
  localparam int unsigned StgEx  = 0;
  localparam int unsigned StgMem = 1;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StStall = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_match_prio.sv
// Matches one ID source operand against all producer stages.
// Ports:
//   i_rs       - ID source register index
//   i_used     - instruction actually reads i_rs
//   i_prod_wr  - destination register of stage k (slice k)
//   i_prod_we  - stage k writes the register file
//   i_prod_rdy - stage k result is forwardable next cycle
//   o_hit      - some stage matches
//   o_idx      - winning (youngest) matching stage
//   o_rdy      - ready flag of the winning stage (1 when no hit)
module fwd_match_prio
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REGW = RegwDef,
  parameter int unsigned NSTG = 2,
  parameter int unsigned IDXW = 1
) (
  input  logic [REGW-1:0]      i_rs,
  input  logic                 i_used,
  input  logic [NSTG*REGW-1:0] i_prod_wr,
  input  logic [NSTG-1:0]      i_prod_we,
  input  logic [NSTG-1:0]      i_prod_rdy,
  output logic                 o_hit,
  output logic [IDXW-1:0]      o_idx,
  output logic                 o_rdy
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = IDXW'(StgEx);
    o_rdy = 1'b1;
    // Walk from oldest to youngest so the youngest match is the last one written.
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (i_used && i_prod_we[k] && (i_prod_wr[k*REGW +: REGW] == i_rs) && (i_rs != '0)) begin
        o_hit = 1'b1;
        o_idx = IDXW'(k);
        o_rdy = i_prod_rdy[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit.
// Compares the ID source registers against NSTG producer stages, registers a
// per-operand forward decision into ID/EX and drives the forwarded operands in EX.
// Ports:
//   i_clk, i_rst_n          - clock, synchronous active-low reset
//   i_id_rs1/2, i_id_rs1/2_used - ID source operands and their use flags
//   i_prod_wr/we/rdy        - per-stage producer destination, write enable, ready
//   i_fwd_src_data          - per-stage result of last cycle's occupant
//   i_ex_hold, i_flush      - EX freeze, squash of the ID instruction
//   o_fwd_a/b_sel, o_fwd_a/b_data - forward selects and forwarded operands
//   o_stall_id              - load-use stall (combinational)
//   o_stall_cnt             - saturating stall-cycle counter
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned XLEN = XlenDef,
  parameter int unsigned REGW = RegwDef,
  parameter int unsigned NSTG = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [REGW-1:0]      i_id_rs1,
  input  logic [REGW-1:0]      i_id_rs2,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic [NSTG*REGW-1:0] i_prod_wr,
  input  logic [NSTG-1:0]      i_prod_we,
  input  logic [NSTG-1:0]      i_prod_rdy,
  input  logic [NSTG*XLEN-1:0] i_fwd_src_data,
  input  logic                 i_ex_hold,
  input  logic                 i_flush,
  output logic                 o_fwd_a_sel,
  output logic                 o_fwd_b_sel,
  output logic [XLEN-1:0]      o_fwd_a_data,
  output logic [XLEN-1:0]      o_fwd_b_data,
  output logic                 o_stall_id,
  output logic [CNTW-1:0]      o_stall_cnt
);

  localparam int unsigned IDXW = (NSTG > 1) ? $clog2(NSTG) : 1;

  logic            w_hit_a, w_hit_b, w_rdy_a, w_rdy_b, w_stall;
  logic [IDXW-1:0] w_idx_a, w_idx_b;

  logic            r_sel_a, r_sel_b, w_sel_a_d, w_sel_b_d;
  logic [IDXW-1:0] r_idx_a, r_idx_b, w_idx_a_d, w_idx_b_d;
  logic [CNTW-1:0] r_stall_cnt, w_stall_cnt_d;
  state_e          r_state, w_state_d;

  fwd_match_prio #(
    .REGW(REGW),
    .NSTG(NSTG),
    .IDXW(IDXW)
  ) u_match_a (
    .i_rs      (i_id_rs1),
    .i_used    (i_id_rs1_used),
    .i_prod_wr (i_prod_wr),
    .i_prod_we (i_prod_we),
    .i_prod_rdy(i_prod_rdy),
    .o_hit     (w_hit_a),
    .o_idx     (w_idx_a),
    .o_rdy     (w_rdy_a)
  );

  fwd_match_prio #(
    .REGW(REGW),
    .NSTG(NSTG),
    .IDXW(IDXW)
  ) u_match_b (
    .i_rs      (i_id_rs2),
    .i_used    (i_id_rs2_used),
    .i_prod_wr (i_prod_wr),
    .i_prod_we (i_prod_we),
    .i_prod_rdy(i_prod_rdy),
    .o_hit     (w_hit_b),
    .o_idx     (w_idx_b),
    .o_rdy     (w_rdy_b)
  );

  // A flushed ID instruction never needs to wait; stall is also quiet in reset.
  assign w_stall = i_rst_n & ~i_flush & ((w_hit_a & ~w_rdy_a) | (w_hit_b & ~w_rdy_b));

  always_comb begin
    w_sel_a_d     = r_sel_a;
    w_sel_b_d     = r_sel_b;
    w_idx_a_d     = r_idx_a;
    w_idx_b_d     = r_idx_b;
    w_stall_cnt_d = r_stall_cnt;
    w_state_d     = r_state;

    if (i_flush || (!i_ex_hold && w_stall)) begin
      w_sel_a_d = 1'b0;
      w_sel_b_d = 1'b0;
    end else if (!i_ex_hold) begin
      w_sel_a_d = w_hit_a;
      w_sel_b_d = w_hit_b;
      w_idx_a_d = w_idx_a;
      w_idx_b_d = w_idx_b;
    end

    if (w_stall && (r_stall_cnt != '1)) begin
      w_stall_cnt_d = r_stall_cnt + CNTW'(1);
    end

    unique case (r_state)
      StRun:   if (w_stall)  w_state_d = StStall;
      StStall: if (!w_stall) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sel_a     <= 1'b0;
      r_sel_b     <= 1'b0;
      r_idx_a     <= '0;
      r_idx_b     <= '0;
      r_stall_cnt <= '0;
      r_state     <= StRun;
    end else begin
      r_sel_a     <= w_sel_a_d;
      r_sel_b     <= w_sel_b_d;
      r_idx_a     <= w_idx_a_d;
      r_idx_b     <= w_idx_b_d;
      r_stall_cnt <= w_stall_cnt_d;
      r_state     <= w_state_d;
    end
  end

  always_comb begin
    o_fwd_a_data = '0;
    o_fwd_b_data = '0;
    for (int k = 0; k < NSTG; k++) begin
      if (r_sel_a && (r_idx_a == IDXW'(k))) o_fwd_a_data = i_fwd_src_data[k*XLEN +: XLEN];
      if (r_sel_b && (r_idx_b == IDXW'(k))) o_fwd_b_data = i_fwd_src_data[k*XLEN +: XLEN];
    end
  end

  assign o_fwd_a_sel = r_sel_a;
  assign o_fwd_b_sel = r_sel_b;
  assign o_stall_id  = w_stall;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned NSTG = 3;
  localparam int unsigned CNTW = 4;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, kept as plain per-stage arrays.
  logic            rst_n, flush, hold, used1, used2;
  logic [REGW-1:0] rs1, rs2;
  logic [REGW-1:0] m_wr [NSTG];
  logic            m_we [NSTG];
  logic            m_rdy[NSTG];
  logic [XLEN-1:0] m_src[NSTG];

  logic [NSTG*REGW-1:0] prod_wr;
  logic [NSTG-1:0]      prod_we, prod_rdy;
  logic [NSTG*XLEN-1:0] src_data;

  always_comb begin
    prod_wr  = '0;
    prod_we  = '0;
    prod_rdy = '0;
    src_data = '0;
    for (int k = 0; k < NSTG; k++) begin
      prod_wr[k*REGW +: REGW]  = m_wr[k];
      prod_we[k]               = m_we[k];
      prod_rdy[k]              = m_rdy[k];
      src_data[k*XLEN +: XLEN] = m_src[k];
    end
  end

  logic            sel_a, sel_b, stall;
  logic [XLEN-1:0] data_a, data_b;
  logic [CNTW-1:0] cnt;

  fwd_hazard_unit #(
    .XLEN(XLEN),
    .REGW(REGW),
    .NSTG(NSTG),
    .CNTW(CNTW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_id_rs1      (rs1),
    .i_id_rs2      (rs2),
    .i_id_rs1_used (used1),
    .i_id_rs2_used (used2),
    .i_prod_wr     (prod_wr),
    .i_prod_we     (prod_we),
    .i_prod_rdy    (prod_rdy),
    .i_fwd_src_data(src_data),
    .i_ex_hold     (hold),
    .i_flush       (flush),
    .o_fwd_a_sel   (sel_a),
    .o_fwd_b_sel   (sel_b),
    .o_fwd_a_data  (data_a),
    .o_fwd_b_data  (data_b),
    .o_stall_id    (stall),
    .o_stall_cnt   (cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: what EX should see.
  logic e_sel_a, e_sel_b;
  int   e_idx_a, e_idx_b, e_cnt;

  // Youngest stage that will produce rs, or -1.
  function automatic int winner(input logic [REGW-1:0] rs, input logic used);
    for (int k = 0; k < NSTG; k++) begin
      if (used && m_we[k] && (m_wr[k] == rs) && (rs != 0)) return k;
    end
    return -1;
  endfunction

  function automatic logic model_stall();
    int w1, w2;
    w1 = winner(rs1, used1);
    w2 = winner(rs2, used2);
    if (!rst_n || flush) return 1'b0;
    return ((w1 >= 0) && !m_rdy[w1]) || ((w2 >= 0) && !m_rdy[w2]);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic sel, input int idx);
    return sel ? m_src[idx] : '0;
  endfunction

  task automatic clear_inputs();
    rst_n = 1'b1; flush = 1'b0; hold = 1'b0;
    used1 = 1'b0; used2 = 1'b0; rs1 = '0; rs2 = '0;
    for (int k = 0; k < NSTG; k++) begin
      m_wr[k] = '0; m_we[k] = 1'b0; m_rdy[k] = 1'b1; m_src[k] = '0;
    end
  endtask

  // Advance one clock and update the model; sampling happens 1 time unit later.
  task automatic tick();
    logic s;
    int   w1, w2;
    s  = model_stall();
    w1 = winner(rs1, used1);
    w2 = winner(rs2, used2);
    @(posedge clk);
    if (!rst_n) begin
      e_sel_a = 1'b0; e_sel_b = 1'b0; e_idx_a = 0; e_idx_b = 0; e_cnt = 0;
    end else begin
      if (flush || (!hold && s)) begin
        e_sel_a = 1'b0; e_sel_b = 1'b0;
      end else if (!hold) begin
        e_sel_a = (w1 >= 0); e_idx_a = (w1 >= 0) ? w1 : 0;
        e_sel_b = (w2 >= 0); e_idx_b = (w2 >= 0) ? w2 : 0;
      end
      if (s && (e_cnt < CMAX)) e_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_we[0] = 1'b1; m_wr[0] = 5'd2; m_rdy[0] = 1'b0; rs1 = 5'd2; used1 = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    n_cmp++; if (sel_a !== 1'b0 || sel_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_sel got=%0b%0b exp=00", sel_a, sel_b); end
    n_cmp++; if (data_a !== '0 || data_b !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", data_a, data_b); end
    n_cmp++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_ex_hit();
    clear_inputs();
    m_wr[0] = 5'd5; m_we[0] = 1'b1; m_src[0] = 32'hDEADBEEF;
    rs1 = 5'd5; used1 = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hit_stall got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (sel_a !== 1'b1) begin n_fail++; $display("FAIL hit_sel_a got=%0b exp=1", sel_a); end
    n_cmp++; if (data_a !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL hit_data_a got=%h exp=deadbeef", data_a); end
    n_cmp++; if (sel_b !== 1'b0) begin n_fail++; $display("FAIL hit_sel_b got=%0b exp=0", sel_b); end
  endtask

  task automatic test_priority();
    clear_inputs();
    m_wr[0] = 5'd7; m_wr[1] = 5'd9; m_wr[2] = 5'd7;
    for (int k = 0; k < NSTG; k++) m_we[k] = 1'b1;
    m_src[0] = 32'h11; m_src[1] = 32'h22; m_src[2] = 32'h33;
    rs1 = 5'd7; rs2 = 5'd9; used1 = 1'b1; used2 = 1'b1;
    tick();
    n_cmp++; if (data_a !== 32'h11) begin n_fail++; $display("FAIL prio_a got=%h exp=11", data_a); end
    n_cmp++; if (data_b !== 32'h22) begin n_fail++; $display("FAIL prio_b got=%h exp=22", data_b); end
    // Forwarded data tracks the selected stage's current result.
    m_src[0] = 32'h44;
    #1;
    n_cmp++; if (data_a !== 32'h44) begin n_fail++; $display("FAIL prio_live got=%h exp=44", data_a); end
    // Both operands on the same register, youngest stage still wins.
    m_wr[1] = 5'd7; rs2 = 5'd7;
    tick();
    n_cmp++; if (data_b !== 32'h44) begin n_fail++; $display("FAIL prio_same got=%h exp=44", data_b); end
  endtask

  task automatic test_x0_unused();
    clear_inputs();
    m_wr[0] = 5'd0; m_we[0] = 1'b1; m_rdy[0] = 1'b0; rs1 = 5'd0; used1 = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (sel_a !== 1'b0) begin n_fail++; $display("FAIL x0_sel got=%0b exp=0", sel_a); end
    clear_inputs();
    m_wr[0] = 5'd6; m_we[0] = 1'b1; m_rdy[0] = 1'b0; rs2 = 5'd6; used2 = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (sel_b !== 1'b0) begin n_fail++; $display("FAIL unused_sel got=%0b exp=0", sel_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    m_wr[0] = 5'd3; m_we[0] = 1'b1; m_rdy[0] = 1'b0; m_src[0] = 32'h5A5A;
    rs1 = 5'd3; used1 = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0b exp=1", stall); end
    tick();
    n_cmp++; if (sel_a !== 1'b0) begin n_fail++; $display("FAIL lu_sel got=%0b exp=0", sel_a); end
    n_cmp++; if (cnt !== CNTW'(1)) begin n_fail++; $display("FAIL lu_cnt got=%0d exp=1", cnt); end
    m_rdy[0] = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (sel_a !== 1'b1 || data_a !== 32'h5A5A) begin
      n_fail++; $display("FAIL lu_fwd got=%0b/%h exp=1/5a5a", sel_a, data_a); end
    n_cmp++; if (cnt !== CNTW'(1)) begin n_fail++; $display("FAIL lu_cnt_hold got=%0d exp=1", cnt); end
  endtask

  task automatic test_hold();
    clear_inputs();
    m_wr[1] = 5'd8; m_we[1] = 1'b1; m_src[1] = 32'hA5; rs1 = 5'd8; used1 = 1'b1;
    tick();
    hold = 1'b1;
    rs1 = 5'd0; used1 = 1'b0;
    m_wr[0] = 5'd8; m_we[0] = 1'b1; m_src[0] = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      m_src[1] = 32'h100 + i;
      tick();
      n_cmp++; if (sel_a !== 1'b1 || data_a !== (32'h100 + i)) begin
        n_fail++; $display("FAIL hold_%0d got=%0b/%h exp=1/%h", i, sel_a, data_a, 32'h100 + i); end
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    m_wr[0] = 5'd4; m_we[0] = 1'b1; rs1 = 5'd4; used1 = 1'b1; m_src[0] = 32'h77;
    tick();
    m_rdy[0] = 1'b0; flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (sel_a !== 1'b0) begin n_fail++; $display("FAIL flush_sel got=%0b exp=0", sel_a); end
    n_cmp++; if (cnt !== CNTW'(e_cnt)) begin
      n_fail++; $display("FAIL flush_cnt got=%0d exp=%0d", cnt, e_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    m_wr[0] = 5'd4; m_we[0] = 1'b1; rs1 = 5'd4; used1 = 1'b1; m_src[0] = 32'hCAFE;
    tick();
    hold = 1'b1; m_rdy[0] = 1'b0;
    repeat (4) tick();
    n_cmp++; if (sel_a !== 1'b1 || cnt !== CNTW'(4)) begin
      n_fail++; $display("FAIL midstall_pre got=%0b/%0d exp=1/4", sel_a, cnt); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (sel_a !== 1'b1 || cnt !== CNTW'(4) || data_a !== 32'hCAFE) begin
      n_fail++; $display("FAIL midstall_async got=%0b/%0d/%h exp=1/4/cafe", sel_a, cnt, data_a); end
    tick();
    n_cmp++; if (sel_a !== 1'b0 || sel_b !== 1'b0 || data_a !== '0 || cnt !== '0 || stall !== 1'b0)
    begin
      n_fail++;
      $display("FAIL midstall_reset got=%0b%0b/%h/%0d/%0b exp=00/0/0/0", sel_a, sel_b, data_a,
               cnt, stall);
    end
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      rs1   = REGW'($urandom_range(0, 3));
      rs2   = REGW'($urandom_range(0, 3));
      used1 = ($urandom_range(0, 3) != 0);
      used2 = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NSTG; k++) begin
        m_wr[k]  = REGW'($urandom_range(0, 3));
        m_we[k]  = ($urandom_range(0, 3) != 0);
        m_rdy[k] = ($urandom_range(0, 2) != 0);
        m_src[k] = $urandom;
      end
      #1;
      n_cmp++; if (stall !== model_stall()) begin
        n_fail++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, stall, model_stall()); end
      tick();
      n_cmp++; if (sel_a !== e_sel_a || sel_b !== e_sel_b) begin
        n_fail++; $display("FAIL rnd_sel c=%0d got=%0b%0b exp=%0b%0b", c, sel_a, sel_b, e_sel_a, e_sel_b);
      end
      n_cmp++; if (data_a !== exp_data(e_sel_a, e_idx_a) || data_b !== exp_data(e_sel_b, e_idx_b))
      begin
        n_fail++;
        $display("FAIL rnd_data c=%0d got=%h/%h exp=%h/%h", c, data_a, data_b,
                 exp_data(e_sel_a, e_idx_a), exp_data(e_sel_b, e_idx_b));
      end
      n_cmp++; if (cnt !== CNTW'(e_cnt)) begin
        n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, cnt, e_cnt); end
    end
  endtask

  initial begin
    e_sel_a = 1'b0; e_sel_b = 1'b0; e_idx_a = 0; e_idx_b = 0; e_cnt = 0;
    clear_inputs();
    test_reset();
    test_ex_hit();
    test_priority();
    test_x0_unused();
    test_load_use();
    test_hold();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
